// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Holds the FSM state type, the default boot address and the counter widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    localparam logic [31:0]  DEFAULT_RESET_PC   = '0;
    localparam int unsigned  FLUSH_CNT_WIDTH    = 4;
    localparam int unsigned  REDIRECT_CNT_WIDTH = 16;

    // The counter is preloaded with cycles-1 so that flush_out is high for exactly `cycles` cycles.
    function automatic logic [FLUSH_CNT_WIDTH-1:0] flush_preset(input int unsigned cycles);
        return FLUSH_CNT_WIDTH'(cycles - 1);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_sat_counter.sv
// Parameterised saturating up-counter with synchronous active-low reset.
// Counts on each enabled edge and holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program-counter generator: sequential word fetch with valid/ready,
// branch/jump redirect followed by a fixed-length wrong-path flush, redirect counter.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned           FLUSH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          system_stall,
    input  logic                          br_valid,
    input  logic                          br_taken,
    input  logic                          br_is_jump,
    input  logic [ADDR_WIDTH-1:0]         br_target,
    input  logic                          fetch_ready,
    output logic                          fetch_valid,
    output logic [ADDR_WIDTH-1:0]         fetch_pc,
    output logic                          flush_out,
    output logic [REDIRECT_CNT_WIDTH-1:0] redirect_count
);

    fetch_state_e               state_q, state_d;
    logic [FLUSH_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
    logic                       valid_q, valid_d;
    logic                       flush_q, flush_d;
    logic                       redirect;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        flush_d  = flush_q;
        redirect = 1'b0;

        if (!system_stall) begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    pc_d    = RESET_PC;
                end
                ST_RUN: begin
                    // Redirect wins over an accept in the same cycle; the pending request is dropped.
                    if (br_valid && (br_taken || br_is_jump)) begin
                        redirect = 1'b1;
                        pc_d     = br_target;
                        valid_d  = 1'b0;
                        flush_d  = 1'b1;
                        cnt_d    = flush_preset(FLUSH_CYCLES);
                        state_d  = ST_FLUSH;
                    end else if (valid_q && fetch_ready) begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - FLUSH_CNT_WIDTH'(1);
                    end else begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                        flush_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    sat_counter #(
        .WIDTH (REDIRECT_CNT_WIDTH)
    ) u_redirect_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (redirect),
        .count_o (redirect_count)
    );

    assign fetch_valid = valid_q;
    assign fetch_pc    = pc_q;
    assign flush_out   = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus random stimulus,
// compared every cycle against a cycle-count behavioural model.
module tb_fetch_pc_gen;

    localparam int unsigned AW    = 32;
    localparam int unsigned FLUSH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          system_stall;
    logic          br_valid;
    logic          br_taken;
    logic          br_is_jump;
    logic [AW-1:0] br_target;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic          flush_out;
    logic [15:0]   redirect_count;

    logic          sat_rst;
    logic          sat_en;
    logic [3:0]    sat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .ADDR_WIDTH   (AW),
        .RESET_PC     (32'h0),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .system_stall   (system_stall),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_is_jump     (br_is_jump),
        .br_target      (br_target),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .flush_out      (flush_out),
        .redirect_count (redirect_count)
    );

    sat_counter #(
        .WIDTH (4)
    ) u_sat (
        .clk     (clk),
        .reset   (sat_rst),
        .en      (sat_en),
        .count_o (sat_cnt)
    );

    // Behavioural model: remaining flush cycles and a pending boot cycle.
    bit            m_live = 1'b0;
    bit            m_boot;
    int unsigned   m_flush_left;
    logic [AW-1:0] m_pc;
    bit            m_valid;
    int unsigned   m_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            m_live       = 1'b1;
            m_boot       = 1'b1;
            m_flush_left = 0;
            m_pc         = '0;
            m_valid      = 1'b0;
            m_cnt        = 0;
        end else if (m_live && !system_stall) begin
            if (m_boot) begin
                m_boot  = 1'b0;
                m_valid = 1'b1;
                m_pc    = '0;
            end else if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
                if (m_flush_left == 0) m_valid = 1'b1;
            end else if (br_valid && (br_taken || br_is_jump)) begin
                m_pc         = br_target;
                m_valid      = 1'b0;
                m_flush_left = FLUSH;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (m_valid && fetch_ready) begin
                m_pc = m_pc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if (fetch_valid !== m_valid || fetch_pc !== m_pc ||
                flush_out !== (m_flush_left > 0) || redirect_count !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL model t=%0t act v=%0b pc=%h fl=%0b cnt=%0d exp v=%0b pc=%h fl=%0b cnt=%0d",
                         $time, fetch_valid, fetch_pc, flush_out, redirect_count,
                         m_valid, m_pc, (m_flush_left > 0), m_cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic br(input logic v, input logic t, input logic j, input logic [AW-1:0] tgt);
        br_valid   = v;
        br_taken   = t;
        br_is_jump = j;
        br_target  = tgt;
    endtask

    initial begin
        reset = 1'b0; system_stall = 1'b0; fetch_ready = 1'b1;
        br(1'b0, 1'b0, 1'b0, '0);
        sat_rst = 1'b0; sat_en = 1'b0;

        step(2);
        chk("reset_valid", 32'(fetch_valid), 32'h0);
        chk("reset_pc", fetch_pc, 32'h0);
        chk("reset_flush", 32'(flush_out), 32'h0);
        chk("reset_cnt", 32'(redirect_count), 32'h0);
        reset = 1'b1;
        step();
        chk("boot_valid", 32'(fetch_valid), 32'h1);
        chk("boot_pc", fetch_pc, 32'h0);
        for (int unsigned i = 1; i <= 5; i++) begin
            step();
            chk("seq_pc", fetch_pc, 32'(i));
        end

        fetch_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("bp_pc", fetch_pc, 32'h5);
            chk("bp_valid", 32'(fetch_valid), 32'h1);
        end
        fetch_ready = 1'b1;
        step();
        chk("bp_resume", fetch_pc, 32'h6);
        step();
        chk("pre_br_pc", fetch_pc, 32'h7);

        br(1'b1, 1'b1, 1'b0, 32'h40);
        step();
        br(1'b0, 1'b0, 1'b0, '0);
        chk("br_pc", fetch_pc, 32'h40);
        chk("br_flush1", 32'(flush_out), 32'h1);
        chk("br_valid_low", 32'(fetch_valid), 32'h0);
        chk("br_cnt", 32'(redirect_count), 32'h1);
        chk("model_cnt", 32'(m_cnt), 32'h1);
        chk("model_flush_left", 32'(m_flush_left), 32'h2);
        step();
        chk("br_flush2", 32'(flush_out), 32'h1);
        step();
        chk("br_flush_end", 32'(flush_out), 32'h0);
        chk("br_reissue_v", 32'(fetch_valid), 32'h1);
        chk("br_reissue_pc", fetch_pc, 32'h40);
        step();
        chk("br_seq", fetch_pc, 32'h41);

        br(1'b1, 1'b0, 1'b1, 32'h100);
        step();
        chk("jmp_pc", fetch_pc, 32'h100);
        chk("jmp_flush", 32'(flush_out), 32'h1);
        br(1'b1, 1'b1, 1'b0, 32'h999);
        step();
        br(1'b0, 1'b0, 1'b0, '0);
        chk("flush_ignore_pc", fetch_pc, 32'h100);
        chk("flush_ignore_cnt", 32'(redirect_count), 32'h2);
        step();
        chk("jmp_reissue", fetch_pc, 32'h100);
        br(1'b1, 1'b0, 1'b0, 32'h555);
        step();
        br(1'b0, 1'b0, 1'b0, '0);
        chk("nt_pc", fetch_pc, 32'h101);
        chk("nt_flush", 32'(flush_out), 32'h0);

        br(1'b1, 1'b1, 1'b0, 32'h200);
        step();
        system_stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("stall_flush", 32'(flush_out), 32'h1);
            chk("stall_cnt", 32'(redirect_count), 32'h3);
            chk("stall_pc", fetch_pc, 32'h200);
        end
        system_stall = 1'b0;
        br(1'b0, 1'b0, 1'b0, '0);
        step();
        chk("stall_flush_last", 32'(flush_out), 32'h1);
        step();
        chk("stall_release_v", 32'(fetch_valid), 32'h1);
        chk("stall_release_pc", fetch_pc, 32'h200);

        br(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step();
        br(1'b0, 1'b0, 1'b0, '0);
        step(2);
        chk("wrap_pre", fetch_pc, 32'hFFFF_FFFF);
        step();
        chk("wrap_pc", fetch_pc, 32'h0);

        br(1'b1, 1'b1, 1'b0, 32'h300);
        step();
        br(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        step();
        chk("rst_flush_v", 32'(fetch_valid), 32'h0);
        chk("rst_flush_fl", 32'(flush_out), 32'h0);
        chk("rst_flush_pc", fetch_pc, 32'h0);
        chk("rst_flush_cnt", 32'(redirect_count), 32'h0);
        reset = 1'b1;
        step();
        chk("reboot_v", 32'(fetch_valid), 32'h1);

        for (int unsigned i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            system_stall = ($urandom_range(0, 7) == 0);
            fetch_ready  = ($urandom_range(0, 3) != 0);
            br(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom);
            step();
        end
        reset = 1'b1; system_stall = 1'b0;
        br(1'b0, 1'b0, 1'b0, '0);

        step();
        sat_rst = 1'b1; sat_en = 1'b1;
        step(3);
        chk("sat_3", 32'(sat_cnt), 32'h3);
        step(12);
        chk("sat_15", 32'(sat_cnt), 32'hF);
        step(5);
        chk("sat_hold", 32'(sat_cnt), 32'hF);
        sat_rst = 1'b0;
        step();
        chk("sat_reset", 32'(sat_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
